memory_access_multi: RTL and testbench
======================================

Name: memory_access_multi

Overview:
- Parametrised multi-channel read-access controller for the pipelined CPU.
- Replaces fixed two-ROM (kernel/pic) access with NUM_CH synchronous read-only memories.
- Accepts one request (channel, base address, beat count) and issues consecutive word addresses back-to-back to the selected memory, one per cycle.
- Packs the returned DATA_W words into one wide READ word and signals completion with a one-cycle HANDSHAKE pulse.

Parameters:
- NUM_CH, 2: number of memory channels (1..8).
- DATA_W, 16: memory word width.
- WORDS, 3: maximum beats per request; READ width is WORDS*DATA_W.
- ADDR_W, 32: memory address width.
- MEM_LAT, 1: memory read latency in cycles (1..4).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-low reset.
- REQ  in  1  request strobe; sampled only in IDLE.
- CH_SEL  in  3  target channel index.
- ADDRESS  in  ADDR_W  base word address.
- LEN  in  $clog2(WORDS+1)  beat count; 0 or >WORDS means WORDS.
- READ  out  WORDS*DATA_W  assembled data; beat k at [k*DATA_W +: DATA_W].
- HANDSHAKE  out  1  one-cycle completion pulse.
- BUSY  out  1  high while a request is in flight.
- ERR  out  1  one-cycle pulse with HANDSHAKE on an invalid CH_SEL.
- MEM_EN  out  NUM_CH  one-hot read enable per channel.
- MEM_ADDR  out  NUM_CH*ADDR_W  per-channel address, flattened; channel c at [c*ADDR_W +: ADDR_W].
- MEM_RDATA  in  NUM_CH*DATA_W  per-channel read data, flattened.

Behaviour:
- Reset (RESET=0 at posedge):
  - State goes to IDLE.
  - READ, HANDSHAKE, BUSY, ERR, MEM_EN and all MEM_ADDR fields are cleared to 0.
  - In-flight beats are discarded. Reset mid-request produces no HANDSHAKE.
- States:
  - IDLE: on REQ=1, latch CH_SEL, ADDRESS and N (the effective LEN). Clear READ to 0 in the same edge.
    - If CH_SEL >= NUM_CH, go to ERROR.
    - Otherwise go to ISSUE.
  - ISSUE: lasts exactly N cycles. In cycle k (0..N-1):
    - MEM_EN[ch]=1 and MEM_ADDR[ch]=base+k.
    - Addition wraps modulo 2^ADDR_W.
    - After beat N-1, go to DRAIN.
  - DRAIN: waits until all N beats are captured (MEM_LAT cycles after the last issue), then goes to DONE.
  - DONE: HANDSHAKE=1 for one cycle, then IDLE.
  - ERROR: HANDSHAKE=1 and ERR=1 for one cycle, READ=0, no MEM_EN asserted, then IDLE.
- Capture:
  - A valid shift pipeline of depth MEM_LAT tags each issued beat with its index.
  - A beat issued in cycle c is captured from MEM_RDATA[ch] at the end of cycle c+MEM_LAT into READ slot k.
  - Slots k >= N stay 0.
- Timing: REQ sampled at edge t0.
  - Addresses are presented in cycles t0+1..t0+N.
  - HANDSHAKE is high in cycle t0+N+MEM_LAT+1.
  - Example: N=3, MEM_LAT=1 gives HANDSHAKE in cycle t0+5.
- Output validity:
  - READ is stable from the HANDSHAKE cycle until the next accepted request.
  - Non-selected channels keep MEM_EN=0 and MEM_ADDR=0.
- BUSY: high from t0+1 through the HANDSHAKE cycle inclusive.
- Request acceptance:
  - REQ is ignored while BUSY.
  - A REQ held high is re-accepted in the first IDLE cycle after HANDSHAKE; there are no back-to-back requests without an IDLE cycle.
  - CH_SEL, ADDRESS and LEN may change freely after acceptance.

Decomposition:
- Package memory_access_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE, ERROR);
  - MAX_CH=8;
  - MAX_LAT=4;
  - function eff_len(LEN, WORDS).
- Sub-module read_beat_collector:
  - holds the MEM_LAT-deep valid/index pipeline and the READ packing register;
  - inputs: issue strobe, beat index, clear, selected data;
  - outputs: READ, all_captured.

Test Plan:
- Reset mid-ISSUE, released 2 cycles later → all outputs 0, no HANDSHAKE, next REQ serviced normally.
- Single read: CH_SEL=0, ADDRESS=0x10, LEN=0, memory returns addr+0x100 → MEM_ADDR[0] = 0x10,0x11,0x12 in t0+1..t0+3; HANDSHAKE at t0+5; READ=0x0112_0111_0110.
- Channel 1 short read: CH_SEL=1, ADDRESS=0x20, LEN=1 → only MEM_EN[1] pulses once; READ=0x0000_0000_0120; HANDSHAKE at t0+3; MEM_EN[0] never set.
- Wrap-around: ADDRESS=0xFFFF_FFFF, LEN=3 → addresses 0xFFFF_FFFF, 0x0, 0x1; data packed in order.
- Invalid channel: CH_SEL=5 → ERR and HANDSHAKE high together in t0+1, READ=0, no MEM_EN activity.
- Latency/back-pressure: MEM_LAT=3 build, REQ held high continuously → HANDSHAKE at t0+7, second request accepted at t0+8, REQ pulses during BUSY ignored.

Source files
------------

// File: rtl/memory_access_multi_pkg.sv
// Shared types and helpers for the multi-channel read-access controller.
package memory_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned MAX_LAT = 4;

  // A zero or oversized beat count means a full-width request.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned words);
    if ((len == 32'd0) || (len > words)) begin
      return words;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/memory_access_multi_if.sv
// Request/response and memory-side bus of the multi-channel read controller.
interface memory_access_multi_if
  import memory_access_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int WORDS  = 3,
  parameter int ADDR_W = 32
);
  localparam int LEN_W = $clog2(WORDS + 1);

  logic                        REQ;
  logic [$clog2(MAX_CH)-1:0]   CH_SEL;
  logic [ADDR_W-1:0]           ADDRESS;
  logic [LEN_W-1:0]            LEN;
  logic [WORDS*DATA_W-1:0]     READ;
  logic                        HANDSHAKE;
  logic                        BUSY;
  logic                        ERR;
  logic [NUM_CH-1:0]           MEM_EN;
  logic [NUM_CH*ADDR_W-1:0]    MEM_ADDR;
  logic [NUM_CH*DATA_W-1:0]    MEM_RDATA;

  modport master (
    output REQ, CH_SEL, ADDRESS, LEN, MEM_RDATA,
    input  READ, HANDSHAKE, BUSY, ERR, MEM_EN, MEM_ADDR
  );

  modport slave (
    input  REQ, CH_SEL, ADDRESS, LEN, MEM_RDATA,
    output READ, HANDSHAKE, BUSY, ERR, MEM_EN, MEM_ADDR
  );

endinterface

// File: rtl/memory_access_multi_collector.sv
// Tags each issued beat through a MEM_LAT-deep pipeline and packs returned words into READ.
module read_beat_collector #(
  parameter int DATA_W  = 16,
  parameter int WORDS   = 3,
  parameter int MEM_LAT = 1,
  parameter int IDX_W   = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    issue_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic                    clear_i,
  input  logic [DATA_W-1:0]       rdata_i,
  output logic [WORDS*DATA_W-1:0] read_o,
  output logic                    all_captured_o
);

  logic [MEM_LAT-1:0]      vld_q, vld_d;
  logic [IDX_W-1:0]        idx_q [MEM_LAT];
  logic [IDX_W-1:0]        idx_d [MEM_LAT];
  logic [WORDS*DATA_W-1:0] read_q, read_d;

  // Shift the beat tags and drop the tagged word into its slot as it leaves the pipe.
  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = issue_i;
    idx_d[0] = idx_i;
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    read_d = read_q;
    if (clear_i) begin
      read_d = '0;
    end else if (vld_q[MEM_LAT-1] && (32'(idx_q[MEM_LAT-1]) < WORDS)) begin
      read_d[idx_q[MEM_LAT-1]*DATA_W +: DATA_W] = rdata_i;
    end else begin
      read_d = read_q;
    end
    // True when the word captured on this edge (if any) is the last one outstanding.
    all_captured_o = ~issue_i;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      all_captured_o = all_captured_o & ~vld_q[i];
    end
  end

  // Pipeline and packing register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      vld_q  <= '0;
      read_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      read_q <= read_d;
    end
  end

  assign read_o = read_q;

endmodule

// File: rtl/memory_access_multi.sv
// Multi-channel burst read controller: issues consecutive addresses to one ROM channel and packs the beats.
module memory_access_multi
  import memory_access_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 3,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  memory_access_multi_if.slave bus
);

  localparam int LEN_W = $clog2(WORDS + 1);
  localparam int CH_W  = $clog2(MAX_CH);

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [LEN_W-1:0]         n_q, n_d;
  logic [LEN_W-1:0]         beat_q, beat_d;
  logic [NUM_CH-1:0]        mem_en_q, mem_en_d;
  logic [NUM_CH*ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                     hs_q, hs_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  logic                     clear_s;
  logic                     issue_s;
  logic                     issue_next_s;
  logic [CH_W-1:0]          issue_ch_s;
  logic [ADDR_W-1:0]        issue_addr_s;
  logic [DATA_W-1:0]        rdata_sel_s;
  logic                     all_captured_s;
  logic [WORDS*DATA_W-1:0]  read_s;

  assign issue_s = (state_q == ST_ISSUE);

  // Read-data mux for the latched channel.
  always_comb begin
    rdata_sel_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) begin
        rdata_sel_s = bus.MEM_RDATA[c*DATA_W +: DATA_W];
      end else begin
        rdata_sel_s = rdata_sel_s;
      end
    end
  end

  // Next-state logic; memory-side outputs are precomputed so they appear one edge after the decision.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    base_d       = base_q;
    n_d          = n_q;
    beat_d       = beat_q;
    clear_s      = 1'b0;
    issue_next_s = 1'b0;
    issue_ch_s   = ch_q;
    issue_addr_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ) begin
          ch_d    = bus.CH_SEL;
          base_d  = bus.ADDRESS;
          n_d     = LEN_W'(eff_len(32'(bus.LEN), WORDS));
          beat_d  = '0;
          clear_s = 1'b1;
          if (32'(bus.CH_SEL) >= NUM_CH) begin
            state_d = ST_ERROR;
          end else begin
            state_d      = ST_ISSUE;
            issue_next_s = 1'b1;
            issue_ch_s   = bus.CH_SEL;
            issue_addr_s = bus.ADDRESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (beat_q == (n_q - LEN_W'(1))) begin
          state_d = ST_DRAIN;
        end else begin
          beat_d       = beat_q + LEN_W'(1);
          issue_next_s = 1'b1;
          issue_addr_s = base_q + ADDR_W'(beat_q) + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (all_captured_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    mem_en_d   = '0;
    mem_addr_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mem_en_d[c] = issue_next_s && (issue_ch_s == CH_W'(c));
      mem_addr_d[c*ADDR_W +: ADDR_W] = mem_en_d[c] ? issue_addr_s : '0;
    end
    hs_d   = (state_d == ST_DONE) || (state_d == ST_ERROR);
    err_d  = (state_d == ST_ERROR);
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      base_q     <= '0;
      n_q        <= '0;
      beat_q     <= '0;
      mem_en_q   <= '0;
      mem_addr_q <= '0;
      hs_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      base_q     <= base_d;
      n_q        <= n_d;
      beat_q     <= beat_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      hs_q       <= hs_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  read_beat_collector #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .MEM_LAT(MEM_LAT),
    .IDX_W  (LEN_W)
  ) u_collector (
    .CLK           (CLK),
    .RESET         (RESET),
    .issue_i       (issue_s),
    .idx_i         (beat_q),
    .clear_i       (clear_s),
    .rdata_i       (rdata_sel_s),
    .read_o        (read_s),
    .all_captured_o(all_captured_s)
  );

  assign bus.READ      = read_s;
  assign bus.HANDSHAKE = hs_q;
  assign bus.BUSY      = busy_q;
  assign bus.ERR       = err_q;
  assign bus.MEM_EN    = mem_en_q;
  assign bus.MEM_ADDR  = mem_addr_q;

endmodule

// File: tb/tb_memory_access_multi.sv
// Bench for memory_access_multi: a MEM_LAT=1 and a MEM_LAT=3 instance driven in lockstep against a timing model.
module tb_memory_access_multi;

  logic clk = 1'b0;
  logic rst_n;
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  always #5 clk = ~clk;

  memory_access_multi_if #(.NUM_CH(2), .DATA_W(16), .WORDS(3), .ADDR_W(32)) if_a ();
  memory_access_multi_if #(.NUM_CH(2), .DATA_W(16), .WORDS(3), .ADDR_W(32)) if_b ();

  memory_access_multi #(.NUM_CH(2), .DATA_W(16), .WORDS(3), .ADDR_W(32), .MEM_LAT(1)) u_dut_a (
    .CLK(clk), .RESET(rst_n), .bus(if_a)
  );
  memory_access_multi #(.NUM_CH(2), .DATA_W(16), .WORDS(3), .ADDR_W(32), .MEM_LAT(3)) u_dut_b (
    .CLK(clk), .RESET(rst_n), .bus(if_b)
  );

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [31:0] s;
    s = a + 32'h0000_0100;
    return s[15:0];
  endfunction

  // Synchronous ROMs: latency 1 for instance A, 3 for instance B.
  logic [15:0] pa [2];
  logic [15:0] pb [2][3];
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (if_a.MEM_EN[c]) pa[c] <= mem_word(if_a.MEM_ADDR[c*32 +: 32]);
      if (if_b.MEM_EN[c]) pb[c][0] <= mem_word(if_b.MEM_ADDR[c*32 +: 32]);
      for (int i = 1; i < 3; i++) pb[c][i] <= pb[c][i-1];
    end
  end
  assign if_a.MEM_RDATA = {pa[1], pa[0]};
  assign if_b.MEM_RDATA = {pb[1][2], pb[0][2]};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input bit req, input int ch, input logic [31:0] addr, input int len);
    if (d == 0) begin
      if_a.REQ = req; if_a.CH_SEL = 3'(ch); if_a.ADDRESS = addr; if_a.LEN = 2'(len);
    end else begin
      if_b.REQ = req; if_b.CH_SEL = 3'(ch); if_b.ADDRESS = addr; if_b.LEN = 2'(len);
    end
  endtask

  task automatic chk_quiet(input string tag, input int d);
    chk($sformatf("%s d%0d read", tag, d), d ? if_b.READ : if_a.READ, 128'd0);
    chk($sformatf("%s d%0d hs", tag, d), d ? if_b.HANDSHAKE : if_a.HANDSHAKE, 128'd0);
    chk($sformatf("%s d%0d busy", tag, d), d ? if_b.BUSY : if_a.BUSY, 128'd0);
    chk($sformatf("%s d%0d err", tag, d), d ? if_b.ERR : if_a.ERR, 128'd0);
    chk($sformatf("%s d%0d en", tag, d), d ? if_b.MEM_EN : if_a.MEM_EN, 128'd0);
    chk($sformatf("%s d%0d addr", tag, d), d ? if_b.MEM_ADDR : if_a.MEM_ADDR, 128'd0);
  endtask

  // One request to both instances; every cycle until both are idle again is checked against the model.
  task automatic run_txn(input string tag, input int ch, input logic [31:0] base, input int len, input bit inject);
    int          n;
    bit          bad_ch;
    int          last_j;
    logic [47:0] exp_read;
    n        = ((len == 0) || (len > 3)) ? 3 : len;
    bad_ch   = (ch >= 2);
    exp_read = '0;
    if (!bad_ch) for (int k = 0; k < n; k++) exp_read[k*16 +: 16] = mem_word(base + 32'(k));
    last_j = bad_ch ? 3 : n + 5;
    @(negedge clk);
    drive(0, 1'b1, ch, base, len);
    drive(1, 1'b1, ch, base, len);
    @(posedge clk);
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      if (j == 1) begin
        drive(0, 1'b0, $urandom_range(0, 7), $urandom, $urandom_range(0, 3));
        drive(1, 1'b0, $urandom_range(0, 7), $urandom, $urandom_range(0, 3));
      end
      if (inject && !bad_ch && (j == 2)) begin
        drive(0, 1'b1, 5, $urandom, $urandom_range(0, 3));
        drive(1, 1'b1, 0, $urandom, $urandom_range(0, 3));
      end
      if (j == 3) begin
        drive(0, 1'b0, 0, 32'd0, 0);
        drive(1, 1'b0, 0, 32'd0, 0);
      end
      for (int d = 0; d < 2; d++) begin
        int           lat;
        int           hsj;
        logic [1:0]   e_en;
        logic [63:0]  e_addr;
        lat    = (d == 0) ? 1 : 3;
        hsj    = bad_ch ? 1 : n + lat + 1;
        e_en   = '0;
        e_addr = '0;
        if (!bad_ch && (j <= n)) begin
          e_en[ch]            = 1'b1;
          e_addr[ch*32 +: 32] = base + 32'(j - 1);
        end
        chk($sformatf("%s d%0d j%0d hs", tag, d, j), d ? if_b.HANDSHAKE : if_a.HANDSHAKE, 128'(j == hsj));
        chk($sformatf("%s d%0d j%0d busy", tag, d, j), d ? if_b.BUSY : if_a.BUSY, 128'(j <= hsj));
        chk($sformatf("%s d%0d j%0d err", tag, d, j), d ? if_b.ERR : if_a.ERR, 128'(bad_ch && (j == 1)));
        chk($sformatf("%s d%0d j%0d en", tag, d, j), d ? if_b.MEM_EN : if_a.MEM_EN, 128'(e_en));
        chk($sformatf("%s d%0d j%0d addr", tag, d, j), d ? if_b.MEM_ADDR : if_a.MEM_ADDR, 128'(e_addr));
        if (j >= hsj) begin
          chk($sformatf("%s d%0d j%0d read", tag, d, j), d ? if_b.READ : if_a.READ, 128'(exp_read));
        end else if (j == 1) begin
          chk($sformatf("%s d%0d j%0d read0", tag, d, j), d ? if_b.READ : if_a.READ, 128'd0);
        end
      end
    end
  endtask

  initial begin
    logic [47:0] held_read;
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 32'd0, 0);
    drive(1, 1'b0, 0, 32'd0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset", 0);
    chk_quiet("reset", 1);
    rst_n = 1'b1;

    // Reset in the middle of the issue phase, held for two edges.
    @(negedge clk);
    drive(0, 1'b1, 0, 32'h0000_0080, 3);
    drive(1, 1'b1, 0, 32'h0000_0080, 3);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, 32'd0, 0);
    drive(1, 1'b0, 0, 32'd0, 0);
    chk("midrst busy a", if_a.BUSY, 128'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("midrst", 0);
    chk_quiet("midrst", 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk_quiet($sformatf("postrst j%0d", j), 0);
      chk_quiet($sformatf("postrst j%0d", j), 1);
    end

    run_txn("single", 0, 32'h0000_0010, 0, 1'b0);
    run_txn("short", 1, 32'h0000_0020, 1, 1'b1);
    run_txn("wrap", 0, 32'hFFFF_FFFF, 3, 1'b0);
    run_txn("badch", 5, 32'h0000_1234, 2, 1'b0);
    run_txn("badch7", 7, 32'h0000_5678, 0, 1'b0);
    for (int t = 0; t < 24; t++) begin
      int ch;
      ch = $urandom_range(0, 4);
      if (ch >= 3) ch = $urandom_range(2, 7);
      run_txn($sformatf("rnd%0d", t), ch, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // REQ held high on the latency-3 instance: re-accepted in the IDLE cycle after HANDSHAKE.
    held_read = {mem_word(32'h42), mem_word(32'h41), mem_word(32'h40)};
    @(negedge clk);
    drive(1, 1'b1, 0, 32'h0000_0040, 0);
    @(posedge clk);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      chk($sformatf("held j%0d hs", j), if_b.HANDSHAKE, 128'(j == 7));
      chk($sformatf("held j%0d busy", j), if_b.BUSY, 128'(j != 8));
      chk($sformatf("held j%0d en", j), if_b.MEM_EN, 128'((j <= 3) || (j == 9)));
      chk($sformatf("held j%0d a idle", j), if_a.BUSY, 128'd0);
      if ((j == 1) || (j == 9)) chk($sformatf("held j%0d addr", j), if_b.MEM_ADDR, 128'h40);
      if ((j == 7) || (j == 8)) chk($sformatf("held j%0d read", j), if_b.READ, 128'(held_read));
    end
    drive(1, 1'b0, 0, 32'd0, 0);
    repeat (10) @(negedge clk);
    chk("held end busy", if_b.BUSY, 128'd0);
    chk("held end read", if_b.READ, 128'(held_read));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
